// File: rtl/tsp16_pkg.sv
// Shared definitions for the tsp16 operand fetch stage and register file.
// Optional build macro: TSP16_ZERO_REG_EN (register 0 hardwired to zero).
package tsp16_pkg;

  localparam int XLEN = 16;
  localparam int NREGS = 8;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [2:0] reg_addr_t;

  typedef enum logic [1:0] {
    TYPE_A = 2'b00,
    TYPE_M = 2'b01,
    TYPE_R = 2'b10,
    TYPE_B = 2'b11
  } itype_e;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_EQUAL = 5'd1,
    OP_OR    = 5'd2,
    OP_AND   = 5'd3,
    OP_MINUS = 5'd4
  } alu_op_e;

  localparam int TYPE_HI = 15;
  localparam int TYPE_LO = 14;
  localparam int OP_HI   = 13;
  localparam int OP_LO   = 9;
  localparam int RD_HI   = 8;
  localparam int RD_LO   = 6;
  localparam int RN_HI   = 5;
  localparam int RN_LO   = 3;
  localparam int RM_HI   = 2;
  localparam int RM_LO   = 0;

`ifdef TSP16_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // A write is "live" when it will actually change architectural state.
  // Writes to r0 are dropped when r0 is hardwired to zero.
  function automatic logic wr_live(input logic en, input reg_addr_t a);
    return en && !(ZERO_REG && (a == '0));
  endfunction

endpackage

// File: rtl/tsp16_regfile.sv
// 8-entry register file: two combinational read ports with write-through
// bypass and one write port. Ports: clk, rst, ra/rb addr+data, wb_en/addr/data.
// Honours TSP16_ZERO_REG_EN (r0 reads as zero, writes to r0 ignored).
module tsp16_regfile
  import tsp16_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  reg_addr_t             ra_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  input  reg_addr_t             rb_addr,
  output logic [DATA_WIDTH-1:0] rb_data,
  input  logic                  wb_en,
  input  reg_addr_t             wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic                  live;

  assign live = wr_live(wb_en, wb_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else if (live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Reads see the value the register will hold after this edge.
  always_comb begin
    ra_data = regs[ra_addr];
    if (ZERO_REG && (ra_addr == '0)) begin
      ra_data = '0;
    end else if (live && (wb_addr == ra_addr)) begin
      ra_data = wb_data;
    end
  end

  always_comb begin
    rb_data = regs[rb_addr];
    if (ZERO_REG && (rb_addr == '0)) begin
      rb_data = '0;
    end else if (live && (wb_addr == rb_addr)) begin
      rb_data = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: accepts an instruction (valid/ready), reads rn/rm from the
// register file and holds instr/rn/rm for the ALU in one pipeline register.
// Ports: clk, rst, in_* handshake, out_* handshake, wb_* write port.
// Optional build macro: TSP16_ZERO_REG_EN.
module operand_fetch_stage
  import tsp16_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_instr,
  output logic [DATA_WIDTH-1:0] out_rn,
  output logic [DATA_WIDTH-1:0] out_rm,
  input  logic                  wb_en,
  input  reg_addr_t             wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  logic                  accept;
  logic                  hold;
  logic                  live;
  logic                  hit_rn;
  logic                  hit_rm;
  reg_addr_t             rn_addr;
  reg_addr_t             rm_addr;
  logic [DATA_WIDTH-1:0] rn_data;
  logic [DATA_WIDTH-1:0] rm_data;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign hold     = out_valid && !out_ready;
  assign rn_addr  = in_instr[RN_HI:RN_LO];
  assign rm_addr  = in_instr[RM_HI:RM_LO];
  assign live     = wr_live(wb_en, wb_addr);
  assign hit_rn   = live && (wb_addr == out_instr[RN_HI:RN_LO]);
  assign hit_rm   = live && (wb_addr == out_instr[RM_HI:RM_LO]);

  tsp16_regfile #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rn_addr),
    .ra_data (rn_data),
    .rb_addr (rm_addr),
    .rb_data (rm_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_rn    <= '0;
      out_rm    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= in_instr;
      out_rn    <= rn_data;
      out_rm    <= rm_data;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Keep stalled operands coherent with the register file.
      if (hold && hit_rn) begin
        out_rn <= wb_data;
      end
      if (hold && hit_rm) begin
        out_rm <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed cases plus random
// traffic compared each cycle against a register-array reference model.
module tb_operand_fetch_stage;
  import tsp16_pkg::*;

`ifdef TSP16_ZERO_REG_EN
  localparam bit Z = 1'b1;
`else
  localparam bit Z = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_rn;
  logic [15:0] out_rm;
  logic        wb_en;
  reg_addr_t   wb_addr;
  logic [15:0] wb_data;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] m_regs [8];
  logic        m_valid;
  logic [15:0] m_instr;
  logic [15:0] m_rn;
  logic [15:0] m_rm;

  always #5 clk = ~clk;

  operand_fetch_stage #(
    .DATA_WIDTH  (16),
    .RESET_VALUE (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_rn    (out_rn),
    .out_rm    (out_rm),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic mreset();
    m_valid = 1'b0;
    m_instr = '0;
    m_rn    = '0;
    m_rm    = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
  endtask

  task automatic drive(input logic iv, input logic [15:0] ins,
                       input logic ordy, input logic we,
                       input logic [2:0] wa, input logic [15:0] wd);
    in_valid  = iv;
    in_instr  = ins;
    out_ready = ordy;
    wb_en     = we;
    wb_addr   = wa;
    wb_data   = wd;
  endtask

  // Model: operands equal the register contents after this edge's write.
  task automatic cycle();
    logic [15:0] nr [8];
    logic        n_valid;
    logic [15:0] n_instr, n_rn, n_rm;
    for (int i = 0; i < 8; i++) nr[i] = m_regs[i];
    if (wb_en) nr[wb_addr] = wb_data;
    if (Z) nr[0] = 16'h0000;
    n_valid = m_valid;
    n_instr = m_instr;
    n_rn    = m_rn;
    n_rm    = m_rm;
    if (in_valid && (!m_valid || out_ready)) begin
      n_valid = 1'b1;
      n_instr = in_instr;
      n_rn    = nr[in_instr[5:3]];
      n_rm    = nr[in_instr[2:0]];
    end else if (m_valid && !out_ready) begin
      n_rn = nr[m_instr[5:3]];
      n_rm = nr[m_instr[2:0]];
    end else if (out_ready) begin
      n_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) m_regs[i] = nr[i];
    m_valid = n_valid;
    m_instr = n_instr;
    m_rn    = n_rn;
    m_rm    = n_rm;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", {15'd0, in_ready}, {15'd0, !m_valid || out_ready});
      check("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
      if (m_valid) begin
        check("out_instr", out_instr, m_instr);
        check("out_rn", out_rn, m_rn);
        check("out_rm", out_rm, m_rm);
      end
    end
  end

  initial begin
    drive(0, 16'h0, 0, 0, 3'd0, 16'h0);
    mreset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_instr", out_instr, 16'h0000);
    check("rst_rn", out_rn, 16'h0000);
    check("rst_rm", out_rm, 16'h0000);
    rst = 1'b0;

    // r1=5, r2=3, then ADD r3,r1,r2
    drive(0, 16'h0, 0, 1, 3'd1, 16'h0005); cycle();
    drive(0, 16'h0, 0, 1, 3'd2, 16'h0003); cycle();
    drive(1, 16'h00CA, 0, 0, 3'd0, 16'h0); cycle();
    check("add_valid", {15'd0, out_valid}, 16'h0001);
    check("add_instr", out_instr, 16'h00CA);
    check("add_rn", out_rn, 16'h0005);
    check("add_rm", out_rm, 16'h0003);

    // Stall with a second instruction pending
    drive(1, 16'h0111, 0, 0, 3'd0, 16'h0);
    #1;
    check("stall_ready", {15'd0, in_ready}, 16'h0000);
    cycle();
    check("stall_instr", out_instr, 16'h00CA);
    check("stall_rn", out_rn, 16'h0005);
    // Refresh of a held operand
    drive(1, 16'h0111, 0, 1, 3'd2, 16'hBEEF); cycle();
    check("refresh_rm", out_rm, 16'hBEEF);
    check("refresh_instr", out_instr, 16'h00CA);
    // Consume and load on the same edge
    drive(1, 16'h0111, 1, 0, 3'd0, 16'h0); cycle();
    check("swap_valid", {15'd0, out_valid}, 16'h0001);
    check("swap_instr", out_instr, 16'h0111);
    check("swap_rn", out_rn, 16'hBEEF);
    check("swap_rm", out_rm, 16'h0005);

    // Write/read bypass
    drive(1, 16'h00CA, 1, 1, 3'd1, 16'h1234); cycle();
    check("bypass_rn", out_rn, 16'h1234);
    check("bypass_rm", out_rm, 16'hBEEF);

    // rn==rm field
    drive(1, 16'h0009, 1, 0, 3'd0, 16'h0); cycle();
    check("same_rn", out_rn, 16'h1234);
    check("same_rm", out_rm, 16'h1234);

    // r0 behaviour
    drive(0, 16'h0, 1, 1, 3'd0, 16'hFFFF); cycle();
    drive(1, 16'h0002, 1, 0, 3'd0, 16'h0); cycle();
    check("r0_rn", out_rn, Z ? 16'h0000 : 16'hFFFF);
    check("r0_rm", out_rm, 16'hBEEF);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), 16'($urandom));
      cycle();
    end

    // Asynchronous reset while holding an instruction
    drive(1, 16'h00CA, 0, 1, 3'd1, 16'h1234); cycle();
    drive(0, 16'h0, 0, 1, 3'd2, 16'hBEEF); cycle();
    check("pre_rst_valid", {15'd0, out_valid}, 16'h0001);
    rst = 1'b1;
    #1;
    check("arst_valid", {15'd0, out_valid}, 16'h0000);
    check("arst_instr", out_instr, 16'h0000);
    check("arst_rn", out_rn, 16'h0000);
    mreset();
    drive(0, 16'h0, 0, 0, 3'd0, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 16'h00CA, 1, 0, 3'd0, 16'h0); cycle();
    check("post_rst_rn", out_rn, 16'h0000);
    check("post_rst_rm", out_rm, 16'h0000);
    drive(0, 16'h0, 1, 0, 3'd0, 16'h0); cycle();
    check("drain_valid", {15'd0, out_valid}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
